// File: rtl/dphy_tx_lane_sequencer_if.sv
// Upstream packet stream into the D-PHY TX lane sequencer: one lane-byte
// pair per transfer, accepted when i_valid & o_ready.
interface dphy_tx_lane_sequencer_if;
  logic       i_valid;
  logic [7:0] i_byte_D1;
  logic [7:0] i_byte_D0;
  logic       i_last;
  logic       o_ready;

  modport master (
    output i_valid,
    output i_byte_D1,
    output i_byte_D0,
    output i_last,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_byte_D1,
    input  i_byte_D0,
    input  i_last,
    output o_ready
  );
endinterface

// File: rtl/dphy_tx_lane_sequencer.sv
// Two-lane MIPI D-PHY TX burst sequencer:
//   LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> clk-post -> LP-11
// Optional build macro DPHY_CONT_CLK_EN: continuous HS clock (enabled in every
// state including IDLE) and a one-cycle CLKPOST.
module dphy_tx_lane_sequencer #(
  parameter int unsigned T_LPX        = 2,
  parameter int unsigned T_HS_PREPARE = 2,
  parameter int unsigned T_HS_ZERO    = 4,
  parameter int unsigned T_HS_TRAIL   = 3,
  parameter int unsigned T_CLK_POST   = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
  input  logic                           i_clk,
  input  logic                           reset,
  input  logic                           i_start,
  dphy_tx_lane_sequencer_if.slave        pkt,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_underrun,
  output logic [7:0]                     byte_D1,
  output logic [7:0]                     byte_D0,
  output logic [1:0]                     lp1_out,
  output logic [1:0]                     lp0_out,
  output logic                           lp1_dir,
  output logic                           lp0_dir,
  output logic                           hs_clk_en,
  output logic                           hs_data_en,
  output logic                           hsxx_clk_en
);

`ifdef DPHY_CONT_CLK_EN
  localparam int unsigned CLKPOST_LEN = 1;
  localparam logic        CLK_IDLE    = 1'b1;
`else
  localparam int unsigned CLKPOST_LEN = T_CLK_POST;
  localparam logic        CLK_IDLE    = 1'b0;
`endif

  localparam int unsigned MAX_A = (T_LPX > T_HS_PREPARE) ? T_LPX : T_HS_PREPARE;
  localparam int unsigned MAX_B = (T_HS_ZERO > T_HS_TRAIL) ? T_HS_ZERO : T_HS_TRAIL;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_T = (MAX_C > T_CLK_POST) ? MAX_C : T_CLK_POST;
  localparam int unsigned CW    = $clog2(MAX_T + 1);

  // Counter loads N-1 on entry; the state is left when it reaches zero.
  localparam logic [CW-1:0] LD_LPX   = CW'(T_LPX - 1);
  localparam logic [CW-1:0] LD_PREP  = CW'(T_HS_PREPARE - 1);
  localparam logic [CW-1:0] LD_ZERO  = CW'(T_HS_ZERO - 1);
  localparam logic [CW-1:0] LD_TRAIL = CW'(T_HS_TRAIL - 1);
  localparam logic [CW-1:0] LD_POST  = CW'(CLKPOST_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LP01,
    S_LP00,
    S_HSZERO,
    S_SYNC,
    S_PAYLOAD,
    S_LASTPAIR,
    S_TRAIL,
    S_CLKPOST
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready;

  logic [1:0] lp_q, lp_d;
  logic [7:0] d1_q, d1_d;
  logic [7:0] d0_q, d0_d;
  logic       clk_q, clk_d;
  logic       data_q, data_d;
  logic       done_q, done_d;

  // Next-state, dwell counter and handshake decode from the current state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready      = 1'b0;
    o_underrun = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LP01;
          cnt_d   = LD_LPX;
        end
      end
      S_LP01: begin
        if (cnt_q == '0) begin
          state_d = S_LP00;
          cnt_d   = LD_PREP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_LP00: begin
        if (cnt_q == '0) begin
          state_d = S_HSZERO;
          cnt_d   = LD_ZERO;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HSZERO: begin
        if (cnt_q == '0) begin
          state_d = S_SYNC;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SYNC, S_PAYLOAD: begin
        ready = 1'b1;
        if (pkt.i_valid) begin
          state_d = pkt.i_last ? S_LASTPAIR : S_PAYLOAD;
        end else begin
          o_underrun = 1'b1;
          state_d    = S_TRAIL;
          cnt_d      = LD_TRAIL;
        end
      end
      // The final pair is still on the lanes here; nothing more is accepted.
      S_LASTPAIR: begin
        state_d = S_TRAIL;
        cnt_d   = LD_TRAIL;
      end
      S_TRAIL: begin
        if (cnt_q == '0) begin
          state_d = S_CLKPOST;
          cnt_d   = LD_POST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_CLKPOST: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // PHY-side values are computed from the next state so they register in
  // step with the state they belong to.
  always_comb begin
    lp_d   = 2'b11;
    d1_d   = '0;
    d0_d   = '0;
    clk_d  = CLK_IDLE;
    data_d = 1'b0;
    done_d = (state_q == S_CLKPOST) && (state_d == S_IDLE);
    case (state_d)
      S_LP01: begin
        lp_d  = 2'b01;
        clk_d = 1'b1;
      end
      S_LP00: begin
        lp_d  = 2'b00;
        clk_d = 1'b1;
      end
      S_HSZERO: begin
        lp_d   = 2'b00;
        clk_d  = 1'b1;
        data_d = 1'b1;
      end
      S_SYNC: begin
        lp_d   = 2'b00;
        clk_d  = 1'b1;
        data_d = 1'b1;
        d1_d   = SYNC_BYTE;
        d0_d   = SYNC_BYTE;
      end
      S_PAYLOAD, S_LASTPAIR: begin
        lp_d   = 2'b00;
        clk_d  = 1'b1;
        data_d = 1'b1;
        d1_d   = pkt.i_byte_D1;
        d0_d   = pkt.i_byte_D0;
      end
      // Lanes serialise LSB first, so the trail is the inverse of bit 7 of
      // whatever byte was last driven (sync byte or payload).
      S_TRAIL: begin
        lp_d   = 2'b00;
        clk_d  = 1'b1;
        data_d = 1'b1;
        if (state_q == S_TRAIL) begin
          d1_d = d1_q;
          d0_d = d0_q;
        end else begin
          d1_d = {8{~d1_q[7]}};
          d0_d = {8{~d0_q[7]}};
        end
      end
      S_CLKPOST: begin
        clk_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and dwell counter registers.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered PHY-side outputs; reset drives the lanes straight to LP-11.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      lp_q   <= 2'b11;
      d1_q   <= '0;
      d0_q   <= '0;
      clk_q  <= 1'b0;
      data_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      lp_q   <= lp_d;
      d1_q   <= d1_d;
      d0_q   <= d0_d;
      clk_q  <= clk_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end

  assign pkt.o_ready = ready;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign byte_D1     = d1_q;
  assign byte_D0     = d0_q;
  assign lp1_out     = lp_q;
  assign lp0_out     = lp_q;
  // Both lanes are transmit-only.
  assign lp1_dir     = 1'b1;
  assign lp0_dir     = 1'b1;
  assign hs_clk_en   = clk_q;
  assign hsxx_clk_en = clk_q;
  assign hs_data_en  = data_q;

endmodule

// File: tb/tb_dphy_tx_lane_sequencer.sv
// Scoreboard bench for dphy_tx_lane_sequencer: each burst's expected per-cycle
// lane activity is built from the protocol phase lengths and queued; a monitor
// compares every cycle the DUT is busy or signalling done, and checks idle
// levels otherwise. Honours DPHY_CONT_CLK_EN when defined.
module tb_dphy_tx_lane_sequencer;

  localparam int unsigned T_LPX        = 2;
  localparam int unsigned T_HS_PREPARE = 2;
  localparam int unsigned T_HS_ZERO    = 4;
  localparam int unsigned T_HS_TRAIL   = 3;
  localparam int unsigned T_CLK_POST   = 4;
  localparam logic [7:0]  SYNC_B       = 8'hB8;
  localparam logic [7:0]  Z8           = 8'h00;

`ifdef DPHY_CONT_CLK_EN
  localparam logic        CK_IDLE = 1'b1;
  localparam int unsigned CP_LEN  = 1;
`else
  localparam logic        CK_IDLE = 1'b0;
  localparam int unsigned CP_LEN  = T_CLK_POST;
`endif

  typedef struct packed {
    logic [1:0] lp1;
    logic [1:0] lp0;
    logic       dir1;
    logic       dir0;
    logic [7:0] d1;
    logic [7:0] d0;
    logic       clk;
    logic       xx;
    logic       data;
    logic       ready;
    logic       busy;
    logic       done;
    logic       under;
  } obs_t;

  logic       clk;
  logic       reset;
  logic       i_start;
  logic       o_busy, o_done, o_underrun;
  logic [7:0] byte_D1, byte_D0;
  logic [1:0] lp1_out, lp0_out;
  logic       lp1_dir, lp0_dir;
  logic       hs_clk_en, hs_data_en, hsxx_clk_en;
  logic       rst_last;

  int checks = 0;
  int errors = 0;

  obs_t       exp_q[$];
  logic [7:0] pd1 [16];
  logic [7:0] pd0 [16];

  dphy_tx_lane_sequencer_if pkt ();

  dphy_tx_lane_sequencer #(
    .T_LPX        (T_LPX),
    .T_HS_PREPARE (T_HS_PREPARE),
    .T_HS_ZERO    (T_HS_ZERO),
    .T_HS_TRAIL   (T_HS_TRAIL),
    .T_CLK_POST   (T_CLK_POST),
    .SYNC_BYTE    (SYNC_B)
  ) dut (
    .i_clk       (clk),
    .reset       (reset),
    .i_start     (i_start),
    .pkt         (pkt),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_underrun  (o_underrun),
    .byte_D1     (byte_D1),
    .byte_D0     (byte_D0),
    .lp1_out     (lp1_out),
    .lp0_out     (lp0_out),
    .lp1_dir     (lp1_dir),
    .lp0_dir     (lp0_dir),
    .hs_clk_en   (hs_clk_en),
    .hs_data_en  (hs_data_en),
    .hsxx_clk_en (hsxx_clk_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rst_last <= reset;

  function automatic obs_t mk(input logic [1:0] lp, input logic [7:0] b1,
                              input logic [7:0] b0, input logic ck, input logic hd,
                              input logic rdy, input logic bsy, input logic dn,
                              input logic ur);
    mk = {lp, lp, 1'b1, 1'b1, b1, b0, ck, ck, hd, rdy, bsy, dn, ur};
  endfunction

  function automatic obs_t sample();
    sample = {lp1_out, lp0_out, lp1_dir, lp0_dir, byte_D1, byte_D0,
              hs_clk_en, hsxx_clk_en, hs_data_en, pkt.o_ready, o_busy, o_done, o_underrun};
  endfunction

  // Expected lane activity of one burst: n pairs offered, the first u of them
  // supplied (u < n means i_valid drops after u pairs).
  task automatic push_burst(input int n, input int u);
    logic [7:0] l1, l0, t1, t0;
    logic       fin;
    for (int i = 0; i < int'(T_LPX); i++)
      exp_q.push_back(mk(2'b01, Z8, Z8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < int'(T_HS_PREPARE); i++)
      exp_q.push_back(mk(2'b00, Z8, Z8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < int'(T_HS_ZERO); i++)
      exp_q.push_back(mk(2'b00, Z8, Z8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b00, SYNC_B, SYNC_B, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, u == 0));
    for (int k = 0; k < u; k++) begin
      fin = (u == n) && (k == n - 1);
      exp_q.push_back(mk(2'b00, pd1[k], pd0[k], 1'b1, 1'b1, !fin, 1'b1, 1'b0,
                         !fin && (k == u - 1)));
    end
    l1 = (u == 0) ? SYNC_B : pd1[u-1];
    l0 = (u == 0) ? SYNC_B : pd0[u-1];
    t1 = l1[7] ? 8'h00 : 8'hFF;
    t0 = l0[7] ? 8'h00 : 8'hFF;
    for (int i = 0; i < int'(T_HS_TRAIL); i++)
      exp_q.push_back(mk(2'b00, t1, t0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < int'(CP_LEN); i++)
      exp_q.push_back(mk(2'b11, Z8, Z8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(2'b11, Z8, Z8, CK_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic chk_reset(input string name);
    obs_t a, e;
    a = sample();
    e = mk(2'b11, Z8, Z8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!o_done && t < 64) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (!o_done) begin
      errors++;
      $display("FAIL done_timeout o_done=%0b required=1", o_done);
    end
  endtask

  // Called at posedge+1 in an idle (or o_done) cycle; returns in the o_done cycle.
  task automatic burst(input int n, input int u, input bit poke);
    push_burst(n, u);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (T_LPX + T_HS_PREPARE + T_HS_ZERO) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < u; k++) begin
      pkt.i_valid   = 1'b1;
      pkt.i_byte_D1 = pd1[k];
      pkt.i_byte_D0 = pd0[k];
      pkt.i_last    = (u == n) && (k == n - 1);
      i_start       = poke && (k < 2);
      @(posedge clk); #1;
    end
    i_start       = 1'b0;
    pkt.i_valid   = 1'b0;
    pkt.i_byte_D1 = 8'($urandom);
    pkt.i_byte_D0 = 8'($urandom);
    pkt.i_last    = (u < n) ? 1'($urandom) : 1'b0;
    @(posedge clk); #1;
    pkt.i_last = 1'b0;
    wait_done();
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      pd1[k] = 8'($urandom);
      pd0[k] = 8'($urandom);
    end
  endtask

  // Monitor: pop and compare whenever the DUT is mid-burst or pulsing done.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      if (!(reset || rst_last)) begin
        a = sample();
        checks++;
        if (o_busy || o_done) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL trace_extra actual=%h required=idle", a);
          end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
              errors++;
              $display("FAIL trace_cycle t=%0t actual=%h required=%h", $time, a, e);
            end
          end
        end else begin
          e = mk(2'b11, Z8, Z8, CK_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          if (a !== e) begin
            errors++;
            $display("FAIL idle_levels t=%0t actual=%h required=%h", $time, a, e);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    reset         = 1'b0;
    i_start       = 1'b0;
    pkt.i_valid   = 1'b0;
    pkt.i_last    = 1'b0;
    pkt.i_byte_D1 = 8'h00;
    pkt.i_byte_D0 = 8'h00;
    #2 reset = 1'b1;
    #1 chk_reset("reset_async");
    repeat (2) @(posedge clk);
    #1 chk_reset("reset_held");
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end

    // Reference burst: (0x11,0x22),(0x33,0xC4 last)
    pd1[0] = 8'h11; pd0[0] = 8'h22;
    pd1[1] = 8'h33; pd0[1] = 8'hC4;
    burst(2, 2, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    // Underrun in SYNC: trail from the sync byte
    fill_random(2);
    burst(2, 0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    // i_start pulsed during payload is ignored
    fill_random(4);
    burst(4, 4, 1'b1);
    repeat (3) begin @(posedge clk); #1; end

    // Reset in HSZERO (cycle 7)
    fill_random(3);
    push_burst(3, 3);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    #1 reset = 1'b1;
    exp_q.delete();
    #1 chk_reset("reset_mid_burst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    fill_random(3);
    burst(3, 3, 1'b0);

    // i_start in the o_done cycle starts the next burst immediately
    fill_random(1);
    burst(1, 1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    // Randomised bursts, underruns and gaps
    for (int b = 0; b < 24; b++) begin
      int n;
      int u;
      n = $urandom_range(1, 6);
      u = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : n;
      fill_random(n);
      burst(n, u, 1'($urandom));
      if ($urandom_range(0, 2) != 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end

    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL trace_leftover actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
